// File: rtl/user_id_controller.sv
// User-ID entry and ROM search stage of the password controller.
// Optional `LOCKOUT_EN adds a consecutive-failure counter and a timed LOCKED state.
module user_id_controller #(
  parameter int unsigned  NUM_USERS   = 8,
  parameter int unsigned  ROM_LAT     = 2,
  parameter int unsigned  MAX_FAILS   = 3,
  parameter int unsigned  LOCK_CYCLES = 1000,
  // Nibble at ROM address a lives in bits [4a+3:4a]; record i is bits [16i+15:16i].
  parameter logic [127:0] ROM_IMAGE   = {16'h9999, 16'hF000, 16'hF000, 16'hF000,
                                         16'hF000, 16'h3C5A, 16'hF000, 16'h4321}
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] UserID_inp,
  input  logic       Load_uid,
  input  logic       Logout_signal,
  output logic       user_id_success,
  output logic [4:0] address_inp,
  output logic [3:0] uid_display,
  output logic       uid_fail,
  output logic       uid_locked
);

  typedef enum logic [3:0] {
    UID_1, UID_2, UID_3, UID_4, FETCH, WAIT, CATCH, SUCCESS, FAIL
`ifdef LOCKOUT_EN
    , LOCKED
`endif
  } state_t;

  state_t      state_q;
  logic [15:0] entered_q;
  logic [4:0]  rom_addr_q;
  logic [3:0]  rom_data_q;
  logic [2:0]  user_q;
  logic [1:0]  digit_q;
  logic [1:0]  wait_q;
  logic        success_q;
  logic [4:0]  address_q;
  logic [3:0]  display_q;
  logic        fail_q;
  logic [3:0]  sel_nib_d;
`ifdef LOCKOUT_EN
  logic [3:0]  fail_cnt_q;
  logic [15:0] lock_cnt_q;
  logic        locked_q;
`endif

  always_comb begin
    sel_nib_d = entered_q[15:12];
    case (digit_q)
      2'd0:    sel_nib_d = entered_q[15:12];
      2'd1:    sel_nib_d = entered_q[11:8];
      2'd2:    sel_nib_d = entered_q[7:4];
      default: sel_nib_d = entered_q[3:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rom_data_q <= '0;
    else        rom_data_q <= ROM_IMAGE[{rom_addr_q, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= UID_1;
      entered_q  <= '0;
      rom_addr_q <= '0;
      user_q     <= '0;
      digit_q    <= '0;
      wait_q     <= '0;
      success_q  <= 1'b0;
      address_q  <= '0;
      display_q  <= '0;
      fail_q     <= 1'b0;
`ifdef LOCKOUT_EN
      fail_cnt_q <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        UID_1: if (Load_uid) begin
          entered_q[15:12] <= UserID_inp;
          display_q        <= UserID_inp;
          state_q          <= UID_2;
        end
        UID_2: if (Load_uid) begin
          entered_q[11:8] <= UserID_inp;
          display_q       <= UserID_inp;
          state_q         <= UID_3;
        end
        UID_3: if (Load_uid) begin
          entered_q[7:4] <= UserID_inp;
          display_q      <= UserID_inp;
          state_q        <= UID_4;
        end
        UID_4: if (Load_uid) begin
          entered_q[3:0] <= UserID_inp;
          display_q      <= UserID_inp;
          user_q         <= '0;
          digit_q        <= '0;
          state_q        <= FETCH;
        end
        FETCH: begin
          rom_addr_q <= {user_q, digit_q};
          wait_q     <= 2'(ROM_LAT - 1);
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wait_q == '0) state_q <= CATCH;
          else              wait_q  <= wait_q - 2'd1;
        end
        // Early abort: the first mismatching digit moves on to the next record.
        CATCH: begin
          if (rom_data_q == sel_nib_d) begin
            if (digit_q == 2'd3) begin
              success_q <= 1'b1;
              address_q <= {user_q, 2'b00};
`ifdef LOCKOUT_EN
              fail_cnt_q <= '0;
`endif
              state_q   <= SUCCESS;
            end else begin
              digit_q <= digit_q + 2'd1;
              state_q <= FETCH;
            end
          end else if (user_q == 3'(NUM_USERS - 1)) begin
            fail_q  <= 1'b1;
            state_q <= FAIL;
          end else begin
            digit_q <= '0;
            user_q  <= user_q + 3'd1;
            state_q <= FETCH;
          end
        end
        SUCCESS: if (Logout_signal) begin
          success_q <= 1'b0;
          address_q <= '0;
          entered_q <= '0;
          state_q   <= UID_1;
        end
        FAIL: begin
          fail_q    <= 1'b0;
          entered_q <= '0;
`ifdef LOCKOUT_EN
          fail_cnt_q <= fail_cnt_q + 4'd1;
          if (4'(fail_cnt_q + 4'd1) == 4'(MAX_FAILS)) begin
            locked_q   <= 1'b1;
            lock_cnt_q <= 16'(LOCK_CYCLES - 1);
            state_q    <= LOCKED;
          end else begin
            state_q <= UID_1;
          end
`else
          state_q <= UID_1;
`endif
        end
`ifdef LOCKOUT_EN
        LOCKED: begin
          if (lock_cnt_q == '0) begin
            locked_q   <= 1'b0;
            fail_cnt_q <= '0;
            state_q    <= UID_1;
          end else begin
            lock_cnt_q <= lock_cnt_q - 16'd1;
          end
        end
`endif
        default: begin
          state_q    <= UID_1;
          entered_q  <= '0;
          rom_addr_q <= '0;
          user_q     <= '0;
          digit_q    <= '0;
          wait_q     <= '0;
          success_q  <= 1'b0;
          address_q  <= '0;
          display_q  <= '0;
          fail_q     <= 1'b0;
`ifdef LOCKOUT_EN
          fail_cnt_q <= '0;
          lock_cnt_q <= '0;
          locked_q   <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign user_id_success = success_q;
  assign address_inp     = address_q;
  assign uid_display     = display_q;
  assign uid_fail        = fail_q;
`ifdef LOCKOUT_EN
  assign uid_locked      = locked_q;
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = (MAX_FAILS == LOCK_CYCLES);
  assign uid_locked      = 1'b0;
`endif

endmodule

// File: tb/tb_user_id_controller.sv
// Scoreboard bench for user_id_controller: stimulus pushes expected search outcomes,
// a negedge monitor pops and compares them when success rises or uid_fail pulses.
module tb_user_id_controller;

  localparam logic [127:0] IMG = {16'h9999, 16'hF000, 16'hF000, 16'hF000,
                                  16'hF000, 16'h3C5A, 16'hF000, 16'h4321};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] UserID_inp = '0;
  logic       Load_uid = 1'b0;
  logic       Logout_signal = 1'b0;
  logic       user_id_success;
  logic [4:0] address_inp;
  logic [3:0] uid_display;
  logic       uid_fail;
  logic       uid_locked;

  user_id_controller #(
    .NUM_USERS  (8),
    .ROM_LAT    (2),
    .MAX_FAILS  (3),
    .LOCK_CYCLES(20),
    .ROM_IMAGE  (IMG)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .UserID_inp     (UserID_inp),
    .Load_uid       (Load_uid),
    .Logout_signal  (Logout_signal),
    .user_id_success(user_id_success),
    .address_inp    (address_inp),
    .uid_display    (uid_display),
    .uid_fail       (uid_fail),
    .uid_locked     (uid_locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_fail;
    logic [4:0] addr;
    logic [3:0] disp;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_load_cyc = 0;
  int   lock_seen = 0;
  logic prev_succ = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Latency is counted in clock edges from the fourth digit's capture edge.
  always @(negedge clk) begin
    exp_t e;
    if (uid_locked) lock_seen++;
    if ((user_id_success && !prev_succ) || uid_fail) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e = sb.pop_front();
        check("event_kind", int'(uid_fail), int'(e.is_fail));
        check("latency", cyc - last_load_cyc, e.lat);
        if (e.is_fail) begin
          check("success_on_fail", int'(user_id_success), 0);
        end else begin
          check("address_inp", int'(address_inp), int'(e.addr));
          check("uid_display", int'(uid_display), int'(e.disp));
        end
      end
    end
    prev_succ = user_id_success;
  end

  task automatic load_digit(input logic [3:0] d);
    @(negedge clk);
    UserID_inp = d;
    Load_uid   = 1'b1;
    @(posedge clk);
    #1;
    last_load_cyc = cyc;
    Load_uid      = 1'b0;
  endtask

  task automatic enter_id(input logic [15:0] id);
    for (int i = 0; i < 4; i++) load_digit(id[15-4*i -: 4]);
  endtask

  task automatic expect_ev(input bit f, input logic [4:0] a, input logic [3:0] d, input int lat);
    exp_t e;
    e.is_fail = f;
    e.addr    = a;
    e.disp    = d;
    e.lat     = lat;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic logout();
    @(negedge clk);
    Logout_signal = 1'b1;
    @(negedge clk);
    Logout_signal = 1'b0;
    check("logout_success", int'(user_id_success), 0);
    check("logout_address", int'(address_inp), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_success"}, int'(user_id_success), 0);
    check({tag, "_address"}, int'(address_inp), 0);
    check({tag, "_display"}, int'(uid_display), 0);
    check({tag, "_fail"},    int'(uid_fail), 0);
    check({tag, "_locked"},  int'(uid_locked), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // T1: user0, then Load ignored in SUCCESS, then Load+Logout together
    enter_id(16'h1234);
    expect_ev(1'b0, 5'd0, 4'h4, 16);
    drain(200);
    load_digit(4'hE);
    check("ignored_load_display", int'(uid_display), 4);
    check("ignored_load_success", int'(user_id_success), 1);
    @(negedge clk);
    UserID_inp    = 4'hE;
    Load_uid      = 1'b1;
    Logout_signal = 1'b1;
    @(negedge clk);
    Load_uid      = 1'b0;
    Logout_signal = 1'b0;
    check("simul_success", int'(user_id_success), 0);
    check("simul_address", int'(address_inp), 0);
    check("simul_display", int'(uid_display), 4);

    // T2: user2 after two early aborts
    enter_id(16'hA5C3);
    expect_ev(1'b0, 5'd8, 4'h3, 24);
    drain(200);
    logout();

    // T3: last user, first digit after logout lands in UID_1
    load_digit(4'h9);
    check("first_digit_display", int'(uid_display), 9);
    load_digit(4'h9);
    load_digit(4'h9);
    load_digit(4'h9);
    expect_ev(1'b0, 5'd28, 4'h9, 44);
    drain(200);
    logout();

    // T4: miss on last digit of user0, then a good ID
    enter_id(16'h1235);
    expect_ev(1'b1, 5'd0, 4'h0, 44);
    drain(200);
    check("post_fail_success", int'(user_id_success), 0);
    enter_id(16'h1234);
    expect_ev(1'b0, 5'd0, 4'h4, 16);
    drain(200);
    logout();

    // T5: asynchronous reset while in WAIT
    enter_id(16'h1234);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midsearch_reset");
    @(negedge clk);
    reset = 1'b1;
    load_digit(4'h1);
    check("post_reset_display", int'(uid_display), 1);
    load_digit(4'h2);
    load_digit(4'h3);
    load_digit(4'h4);
    expect_ev(1'b0, 5'd0, 4'h4, 16);
    drain(200);
    logout();

`ifdef LOCKOUT_EN
    // T6: three misses lock entry for 20 cycles
    lock_seen = 0;
    for (int k = 0; k < 3; k++) begin
      enter_id(16'h1235);
      expect_ev(1'b1, 5'd0, 4'h0, 44);
      drain(200);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      UserID_inp = 4'h8;
      Load_uid   = 1'b1;
    end
    @(negedge clk);
    Load_uid = 1'b0;
    repeat (30) @(negedge clk);
    check("lock_cycles", lock_seen, 20);
    check("unlocked", int'(uid_locked), 0);
    check("locked_load_ignored", int'(uid_display), 5);
    enter_id(16'h1234);
    expect_ev(1'b0, 5'd0, 4'h4, 16);
    drain(200);
`else
    check("never_locked", lock_seen, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
